x_seq_ctrl: RTL and testbench
=============================

# x_seq_ctrl

Input sequencer for the LSTM array. It fetches each timestep's input vector from the word-wide input memory, one word per cycle, and packs it into an NUM×WIDTH vector. It then drives the LSTM core's per-timestep control (`sel`, `load_h`, `wr`) for NUM_ITERATIONS timesteps. It sits directly upstream of the `lstm` core and replaces the free-running address counter / shift register / storage register chain with a start/done handshake.

## Interface
- WIDTH, 32, data word width and address width
- NUM, 68, words per input vector
- NUM_ITERATIONS, 8, timesteps per sequence
- LSTM_LAT, 4, cycles from `o_load` until the LSTM outputs are stable (≥1)
- clk  in  1  clock; single clock domain, all flops rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start a sequence; sampled only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the final timestep commits
- o_addr  out  WIDTH  input memory word address
- i_data  in  WIDTH  memory read data, combinational from `o_addr`, sampled same cycle
- o_x  out  NUM*WIDTH  packed input vector to the LSTM `i_x`
- o_load  out  1  high for exactly the one cycle in which a new `o_x` first appears
- o_sel  out  1  0 during timestep 0 (zero initial state), 1 for later timesteps
- o_load_h  out  1  commit pulse for hidden/cell state registers
- o_wr  out  1  commit pulse, coincident with `o_load_h`
- o_step  out  WIDTH  current timestep index

## Operation
- FSM states: IDLE, FETCH, LOAD, WAIT, COMMIT, DONE.
- IDLE: `i_start`=1 → FETCH with step=0, k=0.
- FETCH: `o_addr = step*NUM + k`. Each edge captures `i_data` into word slot k, then k++.
  - Word k occupies `o_x[(NUM-k)*WIDTH-1 : (NUM-1-k)*WIDTH]`, so word 0 is most significant.
  - Capture goes to an assembly buffer. `o_x` stays stable during FETCH.
  - The edge with k=NUM-1 transfers buffer plus the last word to `o_x` → LOAD.
- LOAD: `o_load`=1 for one cycle → WAIT, wait counter=0.
- WAIT: LSTM_LAT cycles → COMMIT.
- COMMIT: `o_load_h`=`o_wr`=1 for one cycle.
  - If step=NUM_ITERATIONS-1 → DONE.
  - Else step++, k=0 → FETCH.
- DONE: `o_done`=1 for one cycle → IDLE.
- `o_sel` = (step≠0), held across the whole timestep.
- Arithmetic: address computed in WIDTH bits, maximum NUM*NUM_ITERATIONS-1, no wrap within a sequence. Counters sized $clog2 of their bound.
- `i_start` is ignored while busy.
- `i_start` held high in IDLE starts a new sequence on the edge after DONE's IDLE cycle.
- Reset mid-operation: immediate return to IDLE. All outputs and counters, including `o_x` and the buffer, are cleared to 0. No `o_done`.

## Timing
- Reset values: `o_busy`, `o_done`, `o_load`, `o_load_h`, `o_wr`, `o_sel` = 0; `o_addr`=0, `o_step`=0, `o_x`=0.
- All outputs derive from registered state only; there is no combinational path from inputs to outputs.
- Cycles per timestep: NUM+LSTM_LAT+2.
- `i_start` edge → first FETCH cycle: 1 cycle.
- Total from start edge to the `o_done` cycle: NUM_ITERATIONS*(NUM+LSTM_LAT+2)+1 cycles.

## Configuration
- `X_SEQ_CTRL_ABORT_EN` defined:
  - Adds input port `i_abort` (1 bit).
  - `i_abort`=1 in any non-IDLE state → IDLE on the next edge.
  - No `o_done`, no `o_load_h`/`o_wr` pulse on that edge. `o_x` is retained; step and k are cleared.
  - Abort wins over a simultaneous COMMIT.
- Undefined: no port; sequences always run to completion.

## Structure
- Shared package `lstm_pkg`: FSM state enum, and a width helper for counter sizing.
- One sub-module: `x_pack_buf`, the NUM-slot word assembly buffer with slot write-enable and a transfer-to-output strobe.

## Test plan
- Basic run:
  - Setup: NUM=4, NUM_ITERATIONS=2, LSTM_LAT=2, memory word = address+1; pulse `i_start`.
  - `o_addr` sequence is 0,1,2,3 then 4,5,6,7.
  - First `o_load` cycle: `o_x`={1,2,3,4} (MS→LS); second: {5,6,7,8}.
  - `o_done` 17 cycles after the start edge.
- Control pulses:
  - `o_sel`=0 through the first COMMIT, 1 afterwards.
  - Exactly two `o_load_h`/`o_wr` pulses, each LSTM_LAT+1 cycles after its `o_load`.
- Start while busy: `i_start` held high the whole run → no restart mid-run; a second sequence begins one cycle after the `o_done` cycle.
- Reset mid-FETCH (k=2, step=1): assert `rst` asynchronously → outputs 0 immediately, no `o_done`; a later start begins at `o_addr`=0.
- Boundary: LSTM_LAT=1, NUM=1 → timestep period 4 cycles; `o_x` equals the single word.
- Abort (`X_SEQ_CTRL_ABORT_EN`): `i_abort` in WAIT of step 0 → IDLE next cycle, no commit pulse, `o_x` still {1,2,3,4}.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM input sequencer: FSM state encoding and
// counter width helper.
package lstm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_COMMIT = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_e;

   // Bits needed to count 0..bound-1; never narrower than one bit.
   function automatic int cnt_w(input int bound);
      if (bound > 1) begin
         return $clog2(bound);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/x_seq_ctrl_if.sv
// Sequencer bus: start/done handshake, input-memory read port and the
// per-timestep LSTM control group.
interface x_seq_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int NUM   = 68
);
   logic                 i_start;
   logic                 o_busy;
   logic                 o_done;
   logic [WIDTH-1:0]     o_addr;
   logic [WIDTH-1:0]     i_data;
   logic [NUM*WIDTH-1:0] o_x;
   logic                 o_load;
   logic                 o_sel;
   logic                 o_load_h;
   logic                 o_wr;
   logic [WIDTH-1:0]     o_step;

   modport master (
      input  i_start, i_data,
      output o_busy, o_done, o_addr, o_x, o_load, o_sel, o_load_h, o_wr, o_step
   );

   modport slave (
      output i_start, i_data,
      input  o_busy, o_done, o_addr, o_x, o_load, o_sel, o_load_h, o_wr, o_step
   );
endinterface

// File: rtl/x_pack_buf.sv
// NUM-slot word assembly buffer; word 0 lands in the most significant slot
// of the packed output, which only changes on a transfer strobe.
module x_pack_buf
   import lstm_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM    = 68,
   parameter int SLOT_W = cnt_w(NUM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [SLOT_W-1:0]    wr_slot,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 xfer,
   output logic [NUM*WIDTH-1:0] x
);

   logic [WIDTH-1:0]     slot_r [NUM];
   logic [NUM*WIDTH-1:0] x_r;
   logic [NUM*WIDTH-1:0] x_n;

   // Packed image of the buffer with the word being written this cycle merged in.
   always_comb begin
      x_n = '0;
      for (int i = 0; i < NUM; i++) begin
         if (wr_slot == SLOT_W'(i)) begin
            x_n[(NUM-i)*WIDTH-1 -: WIDTH] = wr_data;
         end else begin
            x_n[(NUM-i)*WIDTH-1 -: WIDTH] = slot_r[i];
         end
      end
   end

   // Slot storage written one word per fetch cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM; i++) begin
            slot_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM; i++) begin
            if (wr_en && (wr_slot == SLOT_W'(i))) begin
               slot_r[i] <= wr_data;
            end
         end
      end
   end

   // Output vector register, updated only when a full vector is complete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r <= '0;
      end else if (xfer) begin
         x_r <= x_n;
      end
   end

   assign x = x_r;

endmodule

// File: rtl/x_seq_ctrl.sv
// LSTM input sequencer: fetches NUM words per timestep and sequences the core's
// load/commit control. Optional abort input enabled by X_SEQ_CTRL_ABORT_EN.
module x_seq_ctrl
   import lstm_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int NUM            = 68,
   parameter int NUM_ITERATIONS = 8,
   parameter int LSTM_LAT       = 4
) (
   input  logic clk,
   input  logic rst,
`ifdef X_SEQ_CTRL_ABORT_EN
   input  logic i_abort,
`endif
   x_seq_ctrl_if.master bus
);

   localparam int K_W = cnt_w(NUM);
   localparam int S_W = cnt_w(NUM_ITERATIONS);
   localparam int W_W = cnt_w(LSTM_LAT);
   localparam logic [K_W-1:0] K_LAST = K_W'(NUM - 1);
   localparam logic [S_W-1:0] S_LAST = S_W'(NUM_ITERATIONS - 1);
   localparam logic [W_W-1:0] W_LAST = W_W'(LSTM_LAT - 1);

   seq_state_e       state_r, state_n;
   logic [K_W-1:0]   k_r, k_n;
   logic [S_W-1:0]   step_r, step_n;
   logic [W_W-1:0]   wait_r, wait_n;
   logic [WIDTH-1:0] addr_r, addr_n;
   logic             busy_r, done_r, load_r, commit_r, sel_r;
   logic             abort_s, wr_en_s, xfer_s;
   logic [NUM*WIDTH-1:0] x_s;

`ifdef X_SEQ_CTRL_ABORT_EN
   assign abort_s = i_abort;
`else
   assign abort_s = 1'b0;
`endif

   // An aborted fetch must leave the previously presented vector untouched.
   assign wr_en_s = (state_r == ST_FETCH) && !abort_s;
   assign xfer_s  = wr_en_s && (k_r == K_LAST);

   // Next-state and counter update for the timestep sequence.
   always_comb begin
      state_n = state_r;
      k_n     = k_r;
      step_n  = step_r;
      wait_n  = wait_r;
      if (abort_s && (state_r != ST_IDLE)) begin
         state_n = ST_IDLE;
         k_n     = '0;
         step_n  = '0;
         wait_n  = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.i_start) begin
                  state_n = ST_FETCH;
                  k_n     = '0;
                  step_n  = '0;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (k_r == K_LAST) begin
                  state_n = ST_LOAD;
                  k_n     = '0;
               end else begin
                  k_n = k_r + K_W'(1);
               end
            end
            ST_LOAD: begin
               state_n = ST_WAIT;
               wait_n  = '0;
            end
            ST_WAIT: begin
               if (wait_r == W_LAST) begin
                  state_n = ST_COMMIT;
               end else begin
                  wait_n = wait_r + W_W'(1);
               end
            end
            ST_COMMIT: begin
               if (step_r == S_LAST) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_FETCH;
                  step_n  = step_r + S_W'(1);
                  k_n     = '0;
               end
            end
            ST_DONE: begin
               state_n = ST_IDLE;
            end
            default: begin
               state_n = ST_IDLE;
               k_n     = '0;
               step_n  = '0;
               wait_n  = '0;
            end
         endcase
      end
      addr_n = WIDTH'(step_n) * WIDTH'(NUM) + WIDTH'(k_n);
   end

   // State, counters and registered outputs, all decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         k_r      <= '0;
         step_r   <= '0;
         wait_r   <= '0;
         addr_r   <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         load_r   <= 1'b0;
         commit_r <= 1'b0;
         sel_r    <= 1'b0;
      end else begin
         state_r  <= state_n;
         k_r      <= k_n;
         step_r   <= step_n;
         wait_r   <= wait_n;
         addr_r   <= addr_n;
         busy_r   <= (state_n != ST_IDLE);
         done_r   <= (state_n == ST_DONE);
         load_r   <= (state_n == ST_LOAD);
         commit_r <= (state_n == ST_COMMIT);
         sel_r    <= (step_n != '0);
      end
   end

   x_pack_buf #(
      .WIDTH  (WIDTH),
      .NUM    (NUM),
      .SLOT_W (K_W)
   ) u_pack (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_slot (k_r),
      .wr_data (bus.i_data),
      .xfer    (xfer_s),
      .x       (x_s)
   );

   assign bus.o_busy   = busy_r;
   assign bus.o_done   = done_r;
   assign bus.o_addr   = addr_r;
   assign bus.o_x      = x_s;
   assign bus.o_load   = load_r;
   assign bus.o_sel    = sel_r;
   assign bus.o_load_h = commit_r;
   assign bus.o_wr     = commit_r;
   assign bus.o_step   = WIDTH'(step_r);

endmodule

// File: tb/tb_x_seq_ctrl.sv
// Bench for x_seq_ctrl: a 4-word/2-step/lat-2 instance and a 1-word/3-step/lat-1
// instance driven together and compared each cycle against a timeline model.
module tb_x_seq_ctrl;

   localparam int WA = 32, NA = 4, IA = 2, LA = 2;
   localparam int WB = 16, NB = 1, IB = 3, LB = 1;
   localparam int PA = NA + LA + 2;

   logic clk = 1'b0;
   logic rst;
   logic abort_a, abort_b;
   logic [WA-1:0] mem_a [64];
   logic [WB-1:0] mem_b [64];
   int n_checks = 0;
   int n_fail   = 0;
   int cycle_no = 0;
   int cyc_a, cyc_b;
   logic [127:0] xe_a, xe_b;

   always #5 clk = ~clk;

   x_seq_ctrl_if #(.WIDTH(WA), .NUM(NA)) bus_a ();
   x_seq_ctrl_if #(.WIDTH(WB), .NUM(NB)) bus_b ();

   assign bus_a.i_data = mem_a[bus_a.o_addr[5:0]];
   assign bus_b.i_data = mem_b[bus_b.o_addr[5:0]];

   x_seq_ctrl #(.WIDTH(WA), .NUM(NA), .NUM_ITERATIONS(IA), .LSTM_LAT(LA)) dut_a (
      .clk (clk),
      .rst (rst),
`ifdef X_SEQ_CTRL_ABORT_EN
      .i_abort (abort_a),
`endif
      .bus (bus_a.master)
   );

   x_seq_ctrl #(.WIDTH(WB), .NUM(NB), .NUM_ITERATIONS(IB), .LSTM_LAT(LB)) dut_b (
      .clk (clk),
      .rst (rst),
`ifdef X_SEQ_CTRL_ABORT_EN
      .i_abort (abort_b),
`endif
      .bus (bus_b.master)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle_no);
      end
   endtask

   function automatic logic [127:0] word(input bit is_b, input int addr);
      if (is_b) return 128'(mem_b[addr % 64]);
      return 128'(mem_a[addr % 64]);
   endfunction

   // cyc = 0 when idle, otherwise cycles since the start edge (1 = first fetch).
   task automatic advance(input int n, it, l, input logic st, ab, rs, input bit is_b,
                          inout int cyc, inout logic [127:0] xe);
      int p = n + l + 2;
      int t = it * p + 1;
      int w = is_b ? WB : WA;
      int nc;
      if (rs) begin
         cyc = 0;
         xe  = '0;
         return;
      end
      if (ab && cyc != 0) nc = 0;
      else if (cyc == 0)  nc = st ? 1 : 0;
      else if (cyc == t)  nc = 0;
      else                nc = cyc + 1;
      if (nc != 0 && nc != t && ((nc - 1) % p) == n) begin
         xe = '0;
         for (int j = 0; j < n; j++)
            xe |= word(is_b, ((nc - 1) / p) * n + j) << ((n - 1 - j) * w);
      end
      cyc = nc;
   endtask

   task automatic check_dut(input string nm, input int n, it, l, cyc, input logic [127:0] xe,
                            input logic busy, done, load, load_h, wr, sel,
                            input logic [127:0] step, addr, x);
      int p = n + l + 2;
      int t = it * p + 1;
      int s, ph;
      check_eq({nm, ".busy"}, 128'(busy), 128'(cyc != 0));
      check_eq({nm, ".done"}, 128'(done), 128'(cyc == t));
      check_eq({nm, ".x"}, x, xe);
      if (cyc >= 1 && cyc < t) begin
         s  = (cyc - 1) / p;
         ph = (cyc - 1) % p;
         check_eq({nm, ".load"}, 128'(load), 128'(ph == n));
         check_eq({nm, ".load_h"}, 128'(load_h), 128'(ph == n + l + 1));
         check_eq({nm, ".wr"}, 128'(wr), 128'(ph == n + l + 1));
         check_eq({nm, ".sel"}, 128'(sel), 128'(s != 0));
         check_eq({nm, ".step"}, step, 128'(s));
         if (ph < n) check_eq({nm, ".addr"}, addr, 128'(s * n + ph));
      end else begin
         check_eq({nm, ".load_idle"}, 128'(load), 128'(0));
         check_eq({nm, ".load_h_idle"}, 128'(load_h | wr), 128'(0));
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      advance(NA, IA, LA, bus_a.i_start, abort_a, rst, 1'b0, cyc_a, xe_a);
      advance(NB, IB, LB, bus_b.i_start, abort_b, rst, 1'b1, cyc_b, xe_b);
      #1;
      cycle_no++;
      check_dut("A", NA, IA, LA, cyc_a, xe_a, bus_a.o_busy, bus_a.o_done, bus_a.o_load,
                bus_a.o_load_h, bus_a.o_wr, bus_a.o_sel, 128'(bus_a.o_step),
                128'(bus_a.o_addr), 128'(bus_a.o_x));
      check_dut("B", NB, IB, LB, cyc_b, xe_b, bus_b.o_busy, bus_b.o_done, bus_b.o_load,
                bus_b.o_load_h, bus_b.o_wr, bus_b.o_sel, 128'(bus_b.o_step),
                128'(bus_b.o_addr), 128'(bus_b.o_x));
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((bus_a.o_busy || bus_b.o_busy) && k < 200) begin
         run_cycle();
         k++;
      end
      check_eq("idle_timeout", 128'(k < 200), 128'(1));
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = WA'(i + 1);
         mem_b[i] = WB'(i + 1);
      end
   endtask

   initial begin
      int c0, lat_a, lat_b, nld, nlh_a, nlh_b, ld_cyc, k;
      rst = 1'b1;
      abort_a = 1'b0;
      abort_b = 1'b0;
      bus_a.i_start = 1'b0;
      bus_b.i_start = 1'b0;
      cyc_a = 0; cyc_b = 0; xe_a = '0; xe_b = '0;
      fill_ramp();
      repeat (3) run_cycle();
      check_eq("rst_addr_a", 128'(bus_a.o_addr), 128'(0));
      check_eq("rst_step_a", 128'(bus_a.o_step), 128'(0));
      check_eq("rst_sel_a", 128'(bus_a.o_sel), 128'(0));
      check_eq("rst_addr_b", 128'(bus_b.o_addr), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      run_cycle();

      // Basic run on both instances with word = address + 1.
      c0 = cycle_no;
      bus_a.i_start = 1'b1;
      bus_b.i_start = 1'b1;
      run_cycle();
      bus_a.i_start = 1'b0;
      bus_b.i_start = 1'b0;
      lat_a = -1; lat_b = -1; nld = 0; nlh_a = 0; nlh_b = 0; ld_cyc = 0;
      for (int i = 0; i < 60; i++) begin
         run_cycle();
         if (bus_a.o_load) begin
            if (nld == 0) check_eq("first_x_a", bus_a.o_x, 128'h00000001000000020000000300000004);
            else          check_eq("second_x_a", bus_a.o_x, 128'h00000005000000060000000700000008);
            nld++;
            ld_cyc = cycle_no;
         end
         if (bus_a.o_load_h) begin
            nlh_a++;
            check_eq("commit_gap_a", 128'(cycle_no - ld_cyc), 128'(LA + 1));
            check_eq("sel_at_commit_a", 128'(bus_a.o_sel), 128'(nlh_a > 1));
         end
         if (bus_b.o_load_h) nlh_b++;
         if (bus_a.o_done && lat_a < 0) lat_a = cycle_no - c0;
         if (bus_b.o_done && lat_b < 0) lat_b = cycle_no - c0;
      end
      check_eq("done_lat_a", 128'(lat_a), 128'(17));
      check_eq("done_lat_b", 128'(lat_b), 128'(13));
      check_eq("loads_a", 128'(nld), 128'(2));
      check_eq("commits_a", 128'(nlh_a), 128'(2));
      check_eq("commits_b", 128'(nlh_b), 128'(3));

      // Start held high: no mid-run restart, back-to-back sequences.
      bus_a.i_start = 1'b1;
      bus_b.i_start = 1'b1;
      repeat (60) run_cycle();
      bus_a.i_start = 1'b0;
      bus_b.i_start = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of fetching step 1, word 2.
      bus_a.i_start = 1'b1;
      run_cycle();
      bus_a.i_start = 1'b0;
      k = 0;
      while (cyc_a != PA + 3 && k < 50) begin
         run_cycle();
         k++;
      end
      check_eq("rst_reach_timeout", 128'(k < 50), 128'(1));
      check_eq("pre_rst_addr_a", 128'(bus_a.o_addr), 128'(6));
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_busy", 128'(bus_a.o_busy), 128'(0));
      check_eq("async_rst_addr", 128'(bus_a.o_addr), 128'(0));
      check_eq("async_rst_x", 128'(bus_a.o_x), 128'(0));
      check_eq("async_rst_step", 128'(bus_a.o_step), 128'(0));
      check_eq("async_rst_sel", 128'(bus_a.o_sel), 128'(0));
      cyc_a = 0; cyc_b = 0; xe_a = '0; xe_b = '0;
      #1 rst = 1'b0;
      repeat (20) run_cycle();
      bus_a.i_start = 1'b1;
      run_cycle();
      bus_a.i_start = 1'b0;
      check_eq("restart_addr_a", 128'(bus_a.o_addr), 128'(0));
      wait_idle();

      // Randomized memory contents and start pattern.
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = $urandom;
         mem_b[i] = WB'($urandom);
      end
      for (int i = 0; i < 800; i++) begin
         bus_a.i_start = ($urandom_range(0, 3) == 0);
         bus_b.i_start = ($urandom_range(0, 3) == 0);
`ifdef X_SEQ_CTRL_ABORT_EN
         abort_a = ($urandom_range(0, 29) == 0);
         abort_b = ($urandom_range(0, 29) == 0);
`endif
         run_cycle();
      end
      bus_a.i_start = 1'b0;
      bus_b.i_start = 1'b0;
      abort_a = 1'b0;
      abort_b = 1'b0;
      wait_idle();

`ifdef X_SEQ_CTRL_ABORT_EN
      // Abort in the first wait cycle of step 0.
      fill_ramp();
      bus_a.i_start = 1'b1;
      run_cycle();
      bus_a.i_start = 1'b0;
      k = 0;
      while (cyc_a != NA + 2 && k < 50) begin
         run_cycle();
         k++;
      end
      check_eq("abort_reach_timeout", 128'(k < 50), 128'(1));
      abort_a = 1'b1;
      run_cycle();
      abort_a = 1'b0;
      check_eq("abort_busy", 128'(bus_a.o_busy), 128'(0));
      check_eq("abort_commit", 128'(bus_a.o_load_h | bus_a.o_wr), 128'(0));
      check_eq("abort_x_kept", bus_a.o_x, 128'h00000001000000020000000300000004);
      repeat (5) run_cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
